// File: rtl/minized_peri_pkg.sv
// Shared definitions for the PL LED controller: register word indices,
// CTRL bit positions, AXI response codes, FSM state types and a byte-lane
// merge helper used by the register file.
package minized_peri_pkg;

    // Register word indices (byte offset >> 2)
    localparam int unsigned IDX_CTRL    = 0;
    localparam int unsigned IDX_PERIOD  = 1;
    localparam int unsigned IDX_DUTY_G  = 2;
    localparam int unsigned IDX_DUTY_R  = 3;
    localparam int unsigned IDX_WRAPS   = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_G   = 0;
    localparam int unsigned CTRL_EN_R   = 1;
    localparam int unsigned CTRL_BLINK  = 2;
    localparam int unsigned CTRL_CLR    = 3;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    // Write channel: AW and W may arrive in either order; COMMIT is the
    // cycle in which both are held and the register file is updated.
    typedef enum logic [2:0] {
        WR_IDLE,
        WR_GOT_AW,
        WR_GOT_W,
        WR_COMMIT,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    // Replace the byte lanes of old_val selected by strb with new_val.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Shared PWM/blink counter for the two PL LEDs. Counts 0..period while any
// LED is enabled, counts completed periods in wraps, and drives registered
// LED outputs from a compare of the counter against each duty value.
module led_pwm_core #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_g,
    input  logic             en_r,
    input  logic             blink,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty_g,
    input  logic [CNT_W-1:0] duty_r,
    output logic             led_g,
    output logic             led_r,
    output logic [CNT_W-1:0] wraps
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wraps_q, wraps_d;
    logic             led_g_q, led_g_d;
    logic             led_r_q, led_r_d;
    logic             below_r;

    // Next counter/wrap values and LED compares from the current count
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
        cnt_d   = cnt_q;
        wraps_d = wraps_q;
        if (clr) begin
            cnt_d   = '0;
            wraps_d = '0;
        end else if (en_g || en_r) begin
            // ">=" rather than "==" so a PERIOD lowered below cnt wraps at once
            if (cnt_q >= period) begin
                cnt_d   = '0;
                wraps_d = wraps_q + 1'b1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
        below_r = (cnt_q < duty_r);
        led_g_d = en_g && (cnt_q < duty_g);
        led_r_d = en_r && (blink ? !below_r : below_r);
    end

    // Counter, wrap count and LED output registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q   <= '0;
            wraps_q <= '0;
            led_g_q <= 1'b0;
            led_r_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wraps_q <= wraps_d;
            led_g_q <= led_g_d;
            led_r_q <= led_r_d;
        end
    end

    assign led_g = led_g_q;
    assign led_r = led_r_q;
    assign wraps = wraps_q;

endmodule

// File: rtl/axi_lite_led_ctrl.sv
// AXI4-Lite slave holding the LED register file (CTRL, PERIOD, DUTY_G,
// DUTY_R, WRAPS). Independent write and read channel FSMs with registered
// handshake outputs; the PWM counter itself lives in led_pwm_core.
module axi_lite_led_ctrl
    import minized_peri_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              FCLK_CLK0,
    input  logic              FCLK_CLK0_RSTN,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              led_g_o,
    output logic              led_r_o
);

    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] W_CTRL   = IW'(IDX_CTRL);
    localparam logic [IW-1:0] W_PERIOD = IW'(IDX_PERIOD);
    localparam logic [IW-1:0] W_DUTY_G = IW'(IDX_DUTY_G);
    localparam logic [IW-1:0] W_DUTY_R = IW'(IDX_DUTY_R);
    localparam logic [IW-1:0] W_WRAPS  = IW'(IDX_WRAPS);

    // Write channel state
    wr_state_e         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    // Register file
    logic [2:0]        ctrl_q, ctrl_d;
    logic              clr_q, clr_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  duty_g_q, duty_g_d;
    logic [CNT_W-1:0]  duty_r_q, duty_r_d;

    // Read channel state
    rd_state_e         rd_state_q, rd_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs, w_hs, ar_hs;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic [31:0]       wr_merged;
    logic [31:0]       rd_mux_data;
    logic              rd_mux_ok;
    logic [CNT_W-1:0]  wraps;

    // Protection bits and the byte offset within a word carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs  = s_axi_awvalid && awready_q;
    assign w_hs   = s_axi_wvalid  && wready_q;
    assign ar_hs  = s_axi_arvalid && arready_q;
    assign wr_idx = awaddr_q[ADDR_W-1:2];
    assign rd_idx = s_axi_araddr[ADDR_W-1:2];

    // Write FSM next state, address/data capture and register commit
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ctrl_d     = ctrl_q;
        clr_d      = 1'b0;
        period_d   = period_q;
        duty_g_d   = duty_g_q;
        duty_r_d   = duty_r_q;
        wr_merged  = '0;

        if (aw_hs) awaddr_d = s_axi_awaddr;
        if (w_hs) begin
            wdata_d = s_axi_wdata;
            wstrb_d = s_axi_wstrb;
        end

        unique case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_COMMIT;
                else if (aw_hs)    wr_state_d = WR_GOT_AW;
                else if (w_hs)     wr_state_d = WR_GOT_W;
            end
            WR_GOT_AW: if (w_hs)  wr_state_d = WR_COMMIT;
            WR_GOT_W:  if (aw_hs) wr_state_d = WR_COMMIT;
            WR_COMMIT: begin
                bvalid_d   = 1'b1;
                bresp_d    = RESP_OKAY;
                wr_state_d = WR_RESP;
                if (wr_idx == W_CTRL) begin
                    wr_merged = apply_wstrb(32'(ctrl_q), wdata_q, wstrb_q);
                    ctrl_d    = wr_merged[2:0];
                    clr_d     = wr_merged[CTRL_CLR];
                end else if (wr_idx == W_PERIOD) begin
                    wr_merged = apply_wstrb(32'(period_q), wdata_q, wstrb_q);
                    period_d  = CNT_W'(wr_merged);
                end else if (wr_idx == W_DUTY_G) begin
                    wr_merged = apply_wstrb(32'(duty_g_q), wdata_q, wstrb_q);
                    duty_g_d  = CNT_W'(wr_merged);
                end else if (wr_idx == W_DUTY_R) begin
                    wr_merged = apply_wstrb(32'(duty_r_q), wdata_q, wstrb_q);
                    duty_r_d  = CNT_W'(wr_merged);
                end else if (wr_idx != W_WRAPS) begin
                    // WRAPS is read-only but writable without error
                    bresp_d = RESP_SLVERR;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        // Readies are registered so they stay low through reset
        awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_GOT_W);
        wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_GOT_AW);
    end

    // Write FSM and register file flops
    always_ff @(posedge FCLK_CLK0 or negedge FCLK_CLK0_RSTN) begin
        if (!FCLK_CLK0_RSTN) begin
            wr_state_q <= WR_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            ctrl_q     <= '0;
            clr_q      <= 1'b0;
            period_q   <= '0;
            duty_g_q   <= '0;
            duty_r_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            ctrl_q     <= ctrl_d;
            clr_q      <= clr_d;
            period_q   <= period_d;
            duty_g_q   <= duty_g_d;
            duty_r_q   <= duty_r_d;
        end
    end

    // Read address decode against the pre-edge register values
    always_comb begin
        rd_mux_data = '0;
        rd_mux_ok   = 1'b1;
        if (rd_idx == W_CTRL)        rd_mux_data = 32'(ctrl_q);
        else if (rd_idx == W_PERIOD) rd_mux_data = 32'(period_q);
        else if (rd_idx == W_DUTY_G) rd_mux_data = 32'(duty_g_q);
        else if (rd_idx == W_DUTY_R) rd_mux_data = 32'(duty_r_q);
        else if (rd_idx == W_WRAPS)  rd_mux_data = 32'(wraps);
        else                         rd_mux_ok   = 1'b0;
    end

    // Read FSM next state with data/response latched at the AR handshake
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_mux_data;
                    rresp_d    = rd_mux_ok ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    // Read FSM flops
    always_ff @(posedge FCLK_CLK0 or negedge FCLK_CLK0_RSTN) begin
        if (!FCLK_CLK0_RSTN) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    led_pwm_core #(
        .CNT_W (CNT_W)
    ) u_pwm (
        .clk    (FCLK_CLK0),
        .rst_n  (FCLK_CLK0_RSTN),
        .en_g   (ctrl_q[CTRL_EN_G]),
        .en_r   (ctrl_q[CTRL_EN_R]),
        .blink  (ctrl_q[CTRL_BLINK]),
        .clr    (clr_q),
        .period (period_q),
        .duty_g (duty_g_q),
        .duty_r (duty_r_q),
        .led_g  (led_g_o),
        .led_r  (led_r_o),
        .wraps  (wraps)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_led_ctrl.sv
// Directed + randomized bench for axi_lite_led_ctrl. LED and WRAPS
// expectations come from the counter's closed form: after a clearing CTRL
// write the count runs 0..PERIOD repeatedly, so its value and the number of
// completed periods follow from elapsed cycles with mod/div arithmetic.
module tb_axi_lite_led_ctrl;

    localparam int ADDR_W = 5;
    localparam int TMO    = 40;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_PERIOD = 5'h04;
    localparam logic [4:0] OFF_DUTY_G = 5'h08;
    localparam logic [4:0] OFF_DUTY_R = 5'h0C;
    localparam logic [4:0] OFF_WRAPS  = 5'h10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [ADDR_W-1:0] araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic              led_g, led_r;

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_lite_led_ctrl #(.ADDR_W(ADDR_W), .CNT_W(32)) dut (
        .FCLK_CLK0      (clk),
        .FCLK_CLK0_RSTN (rst_n),
        .s_axi_awaddr   (awaddr),
        .s_axi_awprot   (3'b000),
        .s_axi_awvalid  (awvalid),
        .s_axi_awready  (awready),
        .s_axi_wdata    (wdata),
        .s_axi_wstrb    (wstrb),
        .s_axi_wvalid   (wvalid),
        .s_axi_wready   (wready),
        .s_axi_bresp    (bresp),
        .s_axi_bvalid   (bvalid),
        .s_axi_bready   (bready),
        .s_axi_araddr   (araddr),
        .s_axi_arprot   (3'b000),
        .s_axi_arvalid  (arvalid),
        .s_axi_arready  (arready),
        .s_axi_rdata    (rdata),
        .s_axi_rresp    (rresp),
        .s_axi_rvalid   (rvalid),
        .s_axi_rready   (rready),
        .led_g_o        (led_g),
        .led_r_o        (led_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic send_aw(input logic [4:0] addr, input int dly);
        logic rdy, done;
        done = 1'b0;
        repeat (dly) @(negedge clk);
        awaddr  = addr;
        awvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            rdy = awready;
            @(negedge clk);
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        awvalid = 1'b0;
        check("aw_handshake", 32'(done), 32'(1));
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        logic rdy, done;
        done = 1'b0;
        repeat (dly) @(negedge clk);
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            rdy = wready;
            @(negedge clk);
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        wvalid = 1'b0;
        check("w_handshake", 32'(done), 32'(1));
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int unsigned commit_cyc);
        fork
            send_aw(addr, aw_dly);
            send_w(data, strb, w_dly);
        join
        @(negedge clk);
        check("b_latency", 32'(bvalid), 32'(1));
        commit_cyc = cyc;
        for (int i = 0; i < b_dly; i++) begin
            check("bvalid_hold", 32'(bvalid), 32'(1));
            check("awready_low_in_b", 32'(awready), 32'(0));
            check("wready_low_in_b", 32'(wready), 32'(0));
            @(negedge clk);
        end
        resp   = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'(0));
        check("awready_back", 32'(awready), 32'(1));
        check("wready_back", 32'(wready), 32'(1));
    endtask

    task automatic wr_ok(input string tag, input logic [4:0] addr, input logic [31:0] data);
        logic [1:0] resp;
        int unsigned n;
        axi_write(addr, data, 4'hF, 0, 0, 0, resp, n);
        check(tag, 32'(resp), 32'(2'b00));
    endtask

    task automatic axi_read(input logic [4:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output int unsigned hs_cyc);
        logic rdy, done;
        done    = 1'b0;
        araddr  = addr;
        arvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            rdy = arready;
            @(negedge clk);
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        arvalid = 1'b0;
        check("ar_handshake", 32'(done), 32'(1));
        hs_cyc = cyc;
        check("r_latency", 32'(rvalid), 32'(1));
        data = rdata;
        resp = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(rvalid), 32'(1));
            check("rdata_stable", rdata, data);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_drop", 32'(rvalid), 32'(0));
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        logic [1:0] resp;
        int unsigned hs;
        axi_read(addr, 0, data, resp, hs);
        check(tag, data, exp);
        check({tag, "_rresp"}, 32'(resp), 32'(2'b00));
    endtask

    // Program a configuration, clear the counter and compare the LED
    // waveform and WRAPS count against the closed-form expectation.
    task automatic run_cfg(input string tag, input int p, input int dg, input int dr,
                           input logic [2:0] ctrl, input int ncyc);
        logic [1:0]  resp;
        logic [31:0] data;
        int unsigned n0, hs;
        int          d, c;
        logic        eg, er;
        wr_ok({tag, "_wr_period"}, OFF_PERIOD, 32'(p));
        wr_ok({tag, "_wr_duty_g"}, OFF_DUTY_G, 32'(dg));
        wr_ok({tag, "_wr_duty_r"}, OFF_DUTY_R, 32'(dr));
        axi_write(OFF_CTRL, {28'b0, 1'b1, ctrl}, 4'hF, 0, 0, 0, resp, n0);
        check({tag, "_wr_ctrl"}, 32'(resp), 32'(2'b00));
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            d = int'(cyc - n0);
            if (d >= 2) begin
                c  = (d - 2) % (p + 1);
                eg = ctrl[0] && (c < dg);
                er = ctrl[1] && (ctrl[2] ? (c >= dr) : (c < dr));
                check({tag, "_led_g"}, 32'(led_g), 32'(eg));
                check({tag, "_led_r"}, 32'(led_r), 32'(er));
            end
        end
        axi_read(OFF_WRAPS, 0, data, resp, hs);
        check({tag, "_wraps"}, data, 32'((int'(hs - n0) - 2) / (p + 1)));
        rd_check({tag, "_ctrl_rb"}, OFF_CTRL, 32'(ctrl));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data;
        logic [1:0]  resp;
        int unsigned n, hs;
        logic        rdy, done;
        int          p, dg, dr;
        logic [2:0]  ctrl;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'(0));
        check("rst_wready", 32'(wready), 32'(0));
        check("rst_arready", 32'(arready), 32'(0));
        check("rst_bvalid", 32'(bvalid), 32'(0));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", 32'({bresp, rresp}), 32'(0));
        check("rst_leds", 32'({led_g, led_r}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_awready", 32'(awready), 32'(1));
        check("post_rst_wready", 32'(wready), 32'(1));
        check("post_rst_arready", 32'(arready), 32'(1));

        // Byte-strobed write into DUTY_R (still 0 from reset)
        axi_write(OFF_DUTY_R, 32'hAABBCCDD, 4'b0010, 0, 0, 0, resp, n);
        check("strb_bresp", 32'(resp), 32'(2'b00));
        rd_check("strb_readback", OFF_DUTY_R, 32'h0000CC00);

        // W leads AW by 5 cycles, B held off for 4 cycles
        axi_write(OFF_DUTY_G, 32'h12345678, 4'hF, 5, 0, 4, resp, n);
        check("wfirst_bresp", 32'(resp), 32'(2'b00));
        rd_check("wfirst_readback", OFF_DUTY_G, 32'h12345678);

        // Unmapped offsets and the read-only WRAPS register
        axi_read(5'h14, 3, data, resp, hs);
        check("bad_rd_rresp", 32'(resp), 32'(2'b10));
        check("bad_rd_rdata", data, 32'h0);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 0, 2, 0, resp, n);
        check("bad_wr_bresp", 32'(resp), 32'(2'b10));
        rd_check("bad_wr_ctrl", OFF_CTRL, 32'h0);
        rd_check("bad_wr_period", OFF_PERIOD, 32'h0);
        rd_check("bad_wr_duty_g", OFF_DUTY_G, 32'h12345678);
        rd_check("bad_wr_duty_r", OFF_DUTY_R, 32'h0000CC00);
        axi_write(OFF_WRAPS, 32'h0000_FFFF, 4'hF, 1, 0, 0, resp, n);
        check("wraps_wr_bresp", 32'(resp), 32'(2'b00));
        rd_check("wraps_unchanged", OFF_WRAPS, 32'h0);

        // Directed LED configurations and boundaries
        run_cfg("green_p9", 9, 3, 0, 3'b001, 40);
        run_cfg("blink_p3", 3, 2, 1, 3'b111, 24);
        run_cfg("blink_clr", 3, 2, 1, 3'b111, 10);
        run_cfg("period0", 0, 1, 0, 3'b011, 12);
        run_cfg("duty0", 4, 0, 0, 3'b011, 12);
        run_cfg("duty_gt_p", 4, 7, 5, 3'b111, 12);

        // Randomized configurations
        for (int t = 0; t < 6; t++) begin
            p    = int'($urandom_range(0, 12));
            dg   = int'($urandom_range(0, 15));
            dr   = int'($urandom_range(0, 15));
            ctrl = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
            run_cfg("rand", p, dg, dr, ctrl, 30);
        end

        // Reset while a read response is pending and both LEDs are lit
        run_cfg("pre_rst", 2, 9, 9, 3'b011, 4);
        araddr  = OFF_CTRL;
        arvalid = 1'b1;
        done    = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            rdy = arready;
            @(negedge clk);
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        arvalid = 1'b0;
        check("mid_ar_handshake", 32'(done), 32'(1));
        check("mid_rvalid_pending", 32'(rvalid), 32'(1));
        check("mid_leds_on", 32'({led_g, led_r}), 32'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'(0));
        check("mid_rst_leds", 32'({led_g, led_r}), 32'(0));
        check("mid_rst_arready", 32'(arready), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_post_rvalid", 32'(rvalid), 32'(0));
        rd_check("mid_post_ctrl", OFF_CTRL, 32'h0);
        rd_check("mid_post_period", OFF_PERIOD, 32'h0);
        rd_check("mid_post_duty_g", OFF_DUTY_G, 32'h0);
        rd_check("mid_post_duty_r", OFF_DUTY_R, 32'h0);
        rd_check("mid_post_wraps", OFF_WRAPS, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
